// File: rtl/pwm_deadtime_gen_pkg.sv
// Shared definitions for the dead-time PWM modulator.
//   PERIOD_DEF / DEAD_DEF : default carrier half-period and dead-time (clk cycles)
//   dir_e                 : carrier ramp direction
//   cmd_t                 : signed 32-bit duty command type
//   clamp_val / clamp_hit : saturate a 33-bit signed sum into [0, hi]
package pwm_pkg;

    localparam int unsigned PERIOD_DEF = 500;
    localparam int unsigned DEAD_DEF   = 8;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    typedef logic signed [31:0] cmd_t;

    // Clamped value of v into [0, hi].
    function automatic logic [31:0] clamp_val(input logic signed [32:0] v,
                                              input logic [31:0] hi);
        logic signed [32:0] hi_s;
        logic [31:0]        r;
        hi_s = $signed({1'b0, hi});
        if (v < 33'sd0) begin
            r = '0;
        end else if (v > hi_s) begin
            r = hi;
        end else begin
            r = v[31:0];
        end
        return r;
    endfunction

    // High when clamp_val(v, hi) had to saturate.
    function automatic logic clamp_hit(input logic signed [32:0] v,
                                       input logic [31:0] hi);
        logic signed [32:0] hi_s;
        hi_s = $signed({1'b0, hi});
        return (v < 33'sd0) || (v > hi_s);
    endfunction

endpackage

// File: rtl/pwm_deadtime_gen_if.sv
// Bus between the PID controller and the PWM modulator.
//   en, expect_pwm                                      : controller -> modulator
//   pwm_h, pwm_l, sample_strobe, period_start, sat      : modulator -> controller/bridge
interface pwm_deadtime_gen_if;
    import pwm_pkg::*;

    logic en;
    cmd_t expect_pwm;
    logic pwm_h;
    logic pwm_l;
    logic sample_strobe;
    logic period_start;
    logic sat;

    modport master (
        output en,
        output expect_pwm,
        input  pwm_h,
        input  pwm_l,
        input  sample_strobe,
        input  period_start,
        input  sat
    );

    modport slave (
        input  en,
        input  expect_pwm,
        output pwm_h,
        output pwm_l,
        output sample_strobe,
        output period_start,
        output sat
    );

endinterface

// File: rtl/pwm_deadtime_gen_dead_band_leg.sv
// One gate-drive leg with turn-on delay.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (modulator disabled)
//   src        : requested leg state
//   drive      : gated leg drive; falls 1 cycle after src, rises only after src has
//                been high for DEAD cycles (DEAD+1 latency), short pulses are dropped
module dead_band_leg #(
    parameter int unsigned DEAD = 8,
    parameter int unsigned DT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic src,
    output logic drive
);

    logic [DT_W-1:0] run_q, run_d;
    logic            drive_q, drive_d;

    // run_q counts consecutive high cycles of src and saturates at DEAD.
    always_comb begin
        run_d   = run_q;
        drive_d = 1'b0;
        if (clr || !src) begin
            run_d = '0;
        end else if (run_q == DT_W'(DEAD)) begin
            drive_d = 1'b1;
        end else begin
            run_d = run_q + DT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= '0;
            drive_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            drive_q <= drive_d;
        end
    end

    assign drive = drive_q;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Center-aligned PWM with double-buffered duty and dead-time protected outputs.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of pwm_deadtime_gen_if
//                en            modulator enable (low parks the carrier, outputs off)
//                expect_pwm    signed duty command, 0 = mid-scale, sampled at the valley
//                pwm_h/pwm_l   complementary gate drives
//                sample_strobe one-cycle pulse after the carrier peak
//                period_start  one-cycle pulse after the shadow compare loads
//                sat           last loaded command was clamped
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD = PERIOD_DEF,
    parameter int unsigned DEAD   = DEAD_DEF,
    parameter int unsigned CNT_W  = 10,
    parameter int unsigned DT_W   = 4
) (
    input logic               clk,
    input logic               rst_n,
    pwm_deadtime_gen_if.slave bus
);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    dir_e               dir_q, dir_d;
    logic [CNT_W-1:0]   cmp_q, cmp_d;
    logic               sat_q, sat_d;
    logic               strobe_q, strobe_d;
    logic               pstart_q, pstart_d;
    logic signed [32:0] sum;
    logic               at_valley, at_peak;
    logic               raw, raw_n;
    logic               drive_h, drive_l;

    // 33-bit signed so that +/-2^31 commands cannot wrap before clamping.
    assign sum       = $signed({1'b0, 32'(PERIOD / 2)})
                     + $signed({bus.expect_pwm[31], bus.expect_pwm});
    assign at_valley = (cnt_q == '0);
    assign at_peak   = (cnt_q == CNT_W'(PERIOD)) && (dir_q == DIR_UP);

    // Triangle carrier; disabling parks it at the valley, ramping up.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!bus.en) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else begin
            unique case (dir_q)
                DIR_UP: begin
                    if (cnt_q == CNT_W'(PERIOD)) begin
                        cnt_d = CNT_W'(PERIOD - 1);
                        dir_d = DIR_DOWN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DIR_DOWN: begin
                    if (at_valley) begin
                        cnt_d = CNT_W'(1);
                        dir_d = DIR_UP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                    dir_d = DIR_UP;
                end
            endcase
        end
    end

    // Shadow compare load at the valley and the two strobes.
    always_comb begin
        cmp_d    = cmp_q;
        sat_d    = sat_q;
        pstart_d = 1'b0;
        strobe_d = bus.en && at_peak;
        if (bus.en && at_valley) begin
            cmp_d    = CNT_W'(clamp_val(sum, 32'(PERIOD)));
            sat_d    = clamp_hit(sum, 32'(PERIOD));
            pstart_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            dir_q    <= DIR_UP;
            cmp_q    <= CNT_W'(PERIOD / 2);
            sat_q    <= 1'b0;
            strobe_q <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            cmp_q    <= cmp_d;
            sat_q    <= sat_d;
            strobe_q <= strobe_d;
            pstart_q <= pstart_d;
        end
    end

    // Full-scale compare must hold the high side on through the peak as well.
    assign raw   = (cmp_q == CNT_W'(PERIOD)) ? 1'b1 : (cnt_q < cmp_q);
    assign raw_n = ~raw;

    dead_band_leg #(
        .DEAD (DEAD),
        .DT_W (DT_W)
    ) u_leg_h (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~bus.en),
        .src   (raw),
        .drive (drive_h)
    );

    dead_band_leg #(
        .DEAD (DEAD),
        .DT_W (DT_W)
    ) u_leg_l (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~bus.en),
        .src   (raw_n),
        .drive (drive_l)
    );

    assign bus.pwm_h         = drive_h;
    assign bus.pwm_l         = drive_l;
    assign bus.sample_strobe = strobe_q;
    assign bus.period_start  = pstart_q;
    assign bus.sat           = sat_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Self-checking bench for pwm_deadtime_gen (PERIOD=100, DEAD=4).
// A cycle-level reference model runs alongside every clock; table vectors check
// steady-state per-period high counts, hand sequences cover enable and reset corners,
// and a randomized phase exercises arbitrary command/enable patterns.
module tb_pwm_deadtime_gen;

    localparam int P = 100;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n;

    pwm_deadtime_gen_if bus ();

    pwm_deadtime_gen #(
        .PERIOD (P),
        .DEAD   (D),
        .CNT_W  (10),
        .DT_W   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: k = enabled cycles since the carrier was last parked.
    int  k;
    int  cmp_m;
    bit  sat_m;
    bit  hist[$];
    bit  e_h, e_l, e_ss, e_ps;

    function automatic void chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        k     = 0;
        cmp_m = P / 2;
        sat_m = 1'b0;
        hist.delete();
        e_h   = 1'b0;
        e_l   = 1'b0;
        e_ss  = 1'b0;
        e_ps  = 1'b0;
    endfunction

    // Evaluated at each active edge with the inputs sampled there; yields the
    // outputs expected during the following cycle.
    function automatic void model_step();
        int     ph;
        int     c;
        bit     raw;
        bit     all1;
        bit     all0;
        longint s;
        if (!bus.en) begin
            hist.delete();
            e_h  = 1'b0;
            e_l  = 1'b0;
            e_ss = 1'b0;
            e_ps = 1'b0;
            k    = 0;
            return;
        end
        ph  = k % (2 * P);
        c   = (ph <= P) ? ph : 2 * P - ph;
        raw = (cmp_m == P) ? 1'b1 : (c < cmp_m);
        hist.push_back(raw);
        if (hist.size() > D + 1) void'(hist.pop_front());
        // A leg is on when its source was steady for the last DEAD+1 enabled cycles.
        all1 = (hist.size() == D + 1);
        all0 = all1;
        foreach (hist[i]) begin
            if (hist[i]) all0 = 1'b0;
            else         all1 = 1'b0;
        end
        e_h  = all1;
        e_l  = all0;
        e_ss = (c == P);
        e_ps = (c == 0);
        if (c == 0) begin
            s = longint'(P / 2) + longint'(bus.expect_pwm);
            if (s < 0) begin
                cmp_m = 0;
                sat_m = 1'b1;
            end else if (s > P) begin
                cmp_m = P;
                sat_m = 1'b1;
            end else begin
                cmp_m = int'(s);
                sat_m = 1'b0;
            end
        end
        k++;
    endfunction

    function automatic void check_cycle();
        chk("cycle_outputs{h,l,ss,ps,sat}",
            {bus.pwm_h, bus.pwm_l, bus.sample_strobe, bus.period_start, bus.sat},
            {e_h, e_l, e_ss, e_ps, sat_m});
        chk("no_overlap", bus.pwm_h & bus.pwm_l, 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_cycle();
    endtask

    function automatic bit sig(input int which);
        case (which)
            0:       return bus.pwm_h;
            1:       return bus.pwm_l;
            2:       return bus.period_start;
            default: return bus.sample_strobe;
        endcase
    endfunction

    // Ticks until the selected output is high; n = ticks taken.
    task automatic wait_for(input string name, input int which, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sig(which) && n < 450);
        if (!sig(which)) begin
            total++;
            bad++;
            $display("FAIL %s: timeout after %0d cycles, required a pulse", name, n);
        end
    endtask

    typedef struct {
        logic signed [31:0] cmd;
        int                 n_h;
        int                 n_l;
        bit                 sat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n, nh, nl, nss, nps, cnt;

        // Per-period high counts follow from raw high for #{c < cmp} carrier
        // positions (c=0 once, 1..P-1 twice), each leg losing D cycles per turn-on.
        vecs[0]  = '{32'sd0,           95,  97,  1'b0};
        vecs[1]  = '{32'sd30,          155, 37,  1'b0};
        vecs[2]  = '{-32'sd30,         35,  157, 1'b0};
        vecs[3]  = '{32'sd1000,        200, 0,   1'b1};
        vecs[4]  = '{32'sh8000_0000,   0,   200, 1'b1};
        vecs[5]  = '{-32'sd49,         0,   195, 1'b0};
        vecs[6]  = '{-32'sd48,         0,   193, 1'b0};
        vecs[7]  = '{-32'sd46,         3,   189, 1'b0};
        vecs[8]  = '{32'sd50,          200, 0,   1'b0};
        vecs[9]  = '{32'sd51,          200, 0,   1'b1};
        vecs[10] = '{-32'sd50,         0,   200, 1'b0};
        vecs[11] = '{32'sh7fff_ffff,   200, 0,   1'b1};

        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.expect_pwm = '0;
        model_reset();
        #12;
        check_cycle();
        @(negedge clk);
        rst_n  = 1'b1;
        bus.en = 1'b1;

        // Start-up: valley load on the first enabled cycle, strobes 2*P apart.
        tick();
        chk("first_period_start", bus.period_start, 1);
        wait_for("first_strobe", 3, n);
        wait_for("second_strobe", 3, n);
        chk("strobe_spacing", n, 2 * P);

        // Steady-state period shape per command.
        foreach (vecs[i]) begin
            bus.expect_pwm = vecs[i].cmd;
            wait_for("vec_load", 2, n);
            wait_for("vec_settle", 2, n);
            nh = 0; nl = 0; nss = 0; nps = 0;
            repeat (2 * P) begin
                tick();
                nh  += int'(bus.pwm_h);
                nl  += int'(bus.pwm_l);
                nss += int'(bus.sample_strobe);
                nps += int'(bus.period_start);
            end
            chk($sformatf("vec%0d_h_count", i), nh, vecs[i].n_h);
            chk($sformatf("vec%0d_l_count", i), nl, vecs[i].n_l);
            chk($sformatf("vec%0d_strobes", i), nss + nps, 2);
            chk($sformatf("vec%0d_sat", i), bus.sat, vecs[i].sat);
        end

        // Enable dropped while the high side conducts.
        bus.expect_pwm = 32'sd30;
        wait_for("en_load", 2, n);
        wait_for("en_h_on", 0, n);
        bus.en = 1'b0;
        tick();
        chk("en_off_h", bus.pwm_h, 0);
        cnt = 0;
        repeat (30) begin
            tick();
            cnt += int'(bus.sample_strobe) + int'(bus.period_start);
        end
        chk("strobes_while_off", cnt, 0);
        bus.en = 1'b1;
        tick();
        chk("reenable_period_start", bus.period_start, 1);
        wait_for("reenable_h", 0, n);
        chk("reenable_dead_cycles", n, D);

        // Asynchronous reset between edges while the low side conducts.
        bus.expect_pwm = -32'sd30;
        wait_for("rst_load", 2, n);
        wait_for("rst_l_on", 1, n);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_l", bus.pwm_l, 0);
        chk("async_rst_h", bus.pwm_h, 0);
        chk("async_rst_sat", bus.sat, 0);
        chk("async_rst_strobes", {bus.sample_strobe, bus.period_start}, 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_period_start", bus.period_start, 1);
        wait_for("post_rst_h", 0, n);
        chk("post_rst_dead_cycles", n, D);

        // Randomized commands and enable toggles against the model.
        repeat (25) begin
            bus.en = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       bus.expect_pwm = $urandom;
                1, 2:    bus.expect_pwm = int'($urandom_range(0, 120)) - 60;
                default: bus.expect_pwm = ($urandom_range(0, 1) != 0)
                                        ? 48 + int'($urandom_range(0, 4))
                                        : -52 + int'($urandom_range(0, 4));
            endcase
            repeat ($urandom_range(10, 500)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
